ln_input_scaler: RTL and testbench

//  Normalises the unsigned fixed-point operand of the ln(x) approximation unit into [0.75,1.5).

---
 rtl/ln_approx_pkg.sv | 26 ++
 rtl/ln_input_scaler_if.sv | 25 ++
 rtl/ln_range_cmp.sv | 22 ++
 rtl/ln_input_scaler.sv | 124 ++++++++++++
 tb/tb_ln_input_scaler.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/ln_approx_pkg.sv
// Shared constants and scaler state encoding for the ln(x) approximation unit.
// Constants are expressed in Q.16; q16_to_frac rescales them to other fraction widths.
package ln_approx_pkg;

    localparam logic [15:0] LN2_Q      = 16'hB172;
    localparam logic [31:0] SCALE_LOW  = 32'h0000_C000;
    localparam logic [31:0] SCALE_HIGH = 32'h0001_8000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCALE = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERR   = 2'd3
    } scaler_state_t;

    function automatic logic [63:0] q16_to_frac(input logic [63:0] v, input int frac);
        logic [63:0] r;
        if (frac >= 16) begin
            r = v << (frac - 16);
        end else begin
            r = v >> (16 - frac);
        end
        return r;
    endfunction

endpackage

// File: rtl/ln_input_scaler_if.sv
// Start/result bundle between the series controller (master) and the input scaler (slave).
// Level done_o handshake; no backpressure beyond the controller polling done_o.
interface ln_input_scaler_if #(
    parameter int WIDTH = 32,
    parameter int KW    = 7
);
    logic                    start_i;
    logic [WIDTH-1:0]        x_i;
    logic                    busy_o;
    logic                    done_o;
    logic                    err_o;
    logic [WIDTH-1:0]        x_o;
    logic signed [KW-1:0]    k_o;
    logic [WIDTH-1:0]        ln2_corr_o;

    modport master (
        output start_i, x_i,
        input  busy_o, done_o, err_o, x_o, k_o, ln2_corr_o
    );

    modport slave (
        input  start_i, x_i,
        output busy_o, done_o, err_o, x_o, k_o, ln2_corr_o
    );
endinterface

// File: rtl/ln_range_cmp.sv
// Combinational decode of x against the [0.75,1.5) window (unsigned, full width).
// Zero latency; no handshake.
module ln_range_cmp
    import ln_approx_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16
) (
    input  logic [WIDTH-1:0] x,
    output logic             above,
    output logic             below,
    output logic             in_range
);

    localparam logic [WIDTH-1:0] LOW  = WIDTH'(q16_to_frac(64'(SCALE_LOW), FRAC));
    localparam logic [WIDTH-1:0] HIGH = WIDTH'(q16_to_frac(64'(SCALE_HIGH), FRAC));

    assign above    = (x >= HIGH);
    assign below    = (x <  LOW);
    assign in_range = !above && !below;

endmodule

// File: rtl/ln_input_scaler.sv
// Normalises x into [0.75,1.5) by 1-bit shifts, returning signed shift count k; done_o after |k|+2 cycles.
// Starts only accepted when not busy; optional k*ln2 accumulator under LN_SCALER_CORR_EN.
module ln_input_scaler
    import ln_approx_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int KW    = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    ln_input_scaler_if.slave io
);

    // Reset asserts asynchronously but releases on a clock edge.
    logic [1:0] rst_sync_q;
    logic       rst_sync_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_sync_n = rst_sync_q[1];

    scaler_state_t        state_q, state_d;
    logic [WIDTH-1:0]     x_q, x_d;
    logic signed [KW-1:0] k_q, k_d;
    logic                 above, below, in_range;
    logic                 x_bad;

`ifdef LN_SCALER_CORR_EN
    localparam logic [WIDTH-1:0] LN2_STEP = WIDTH'(q16_to_frac(64'(LN2_Q), FRAC));
    logic [WIDTH-1:0] corr_q, corr_d;
`endif

    ln_range_cmp #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_range_cmp (
        .x        (x_q),
        .above    (above),
        .below    (below),
        .in_range (in_range)
    );

    assign x_bad = (io.x_i == '0) || io.x_i[WIDTH-1];

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        k_d     = k_q;
`ifdef LN_SCALER_CORR_EN
        corr_d  = corr_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (io.start_i) begin
                    state_d = x_bad ? ST_ERR : ST_SCALE;
                    x_d     = x_bad ? '0 : io.x_i;
                    k_d     = '0;
`ifdef LN_SCALER_CORR_EN
                    corr_d  = '0;
`endif
                end
            end
            ST_SCALE: begin
                // Only one of the two shift directions can ever fire for a given operand.
                if (above) begin
                    x_d = x_q >> 1;
                    k_d = k_q + $signed(KW'(1));
`ifdef LN_SCALER_CORR_EN
                    corr_d = corr_q + LN2_STEP;
`endif
                end else if (below) begin
                    x_d = x_q << 1;
                    k_d = k_q - $signed(KW'(1));
`ifdef LN_SCALER_CORR_EN
                    corr_d = corr_q - LN2_STEP;
`endif
                end else if (in_range) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            k_q     <= k_d;
        end
    end

`ifdef LN_SCALER_CORR_EN
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            corr_q <= '0;
        end else begin
            corr_q <= corr_d;
        end
    end

    assign io.ln2_corr_o = corr_q;
`else
    assign io.ln2_corr_o = '0;
`endif

    assign io.busy_o = (state_q == ST_SCALE);
    assign io.done_o = (state_q == ST_DONE) || (state_q == ST_ERR);
    assign io.err_o  = (state_q == ST_ERR);
    assign io.x_o    = x_q;
    assign io.k_o    = k_q;

endmodule

// File: tb/tb_ln_input_scaler.sv
// Randomised scoreboard bench for ln_input_scaler: driver queues model results, monitor checks on done_o.
module tb_ln_input_scaler;
    import ln_approx_pkg::*;

    typedef struct {
        logic [31:0]        x;
        logic signed [6:0]  k;
        logic               err;
        logic [31:0]        corr;
        int                 lat;
        bit                 abort;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];

    ln_input_scaler_if #(.WIDTH(32), .KW(7)) bus ();

    ln_input_scaler #(.WIDTH(32), .FRAC(16), .KW(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: normalise with plain arithmetic, k*ln2 in Q.16.
    function automatic exp_t model(input logic [31:0] xin);
        exp_t        e;
        logic [31:0] x;
        int          k;
        x = xin;
        k = 0;
        e.abort = 0;
        if (xin == 32'd0 || xin[31]) begin
            e.x = 0; e.k = 0; e.err = 1; e.corr = 0; e.lat = 1;
            return e;
        end
        while (x >= 32'h0001_8000) begin x = x >> 1; k++; end
        while (x <  32'h0000_C000) begin x = x << 1; k--; end
        e.x   = x;
        e.k   = 7'(k);
        e.err = 0;
`ifdef LN_SCALER_CORR_EN
        e.corr = 32'(k * 45426);
`else
        e.corr = 0;
`endif
        e.lat = ((k < 0) ? -k : k) + 2;
        return e;
    endfunction

    // Monitor: an accepted start pops one expectation; result compared when done_o rises.
    initial begin
        exp_t e;
        int   cnt;
        forever begin
            @(negedge clk);
            if (rst_n && bus.start_i && !bus.busy_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_start", 1, 0);
                end else begin
                    e = sb.pop_front();
                    cnt = 0;
                    if (e.abort) begin
                        while (rst_n && cnt < 200) begin
                            @(negedge clk);
                            cnt++;
                            if (bus.done_o) chk("done_before_reset", 1, 0);
                        end
                        chk("abort_reset_seen", rst_n, 0);
                    end else begin
                        while (cnt < 80) begin
                            @(negedge clk);
                            cnt++;
                            if (bus.done_o) break;
                        end
                        chk("latency", cnt, e.lat);
                        chk("done", bus.done_o, 1);
                        chk("busy", bus.busy_o, 0);
                        chk("err", bus.err_o, e.err);
                        chk("x_o", bus.x_o, e.x);
                        chk("k_o", 64'(bus.k_o), 64'(e.k));
                        chk("ln2_corr", bus.ln2_corr_o, e.corr);
                    end
                end
            end
        end
    end

    task automatic issue(input logic [31:0] xv);
        int n;
        @(posedge clk);
        #1;
        bus.start_i = 1'b1;
        bus.x_i     = xv;
        sb.push_back(model(xv));
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        bus.x_i     = $urandom;
        n = 0;
        while (n < 80) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.done_o) break;
        end
        if (n >= 80) chk("done_timeout", 1, 0);
    endtask

    initial begin
        logic [31:0] dir[10];
        logic [31:0] xv;
        exp_t        ab;
        bit          saw_done;
        dir = '{32'h0001_0000, 32'h0008_0000, 32'h0000_4000, 32'h0001_7FFF, 32'h0001_8000,
                32'h0000_BFFF, 32'h0000_0000, 32'h8000_0000, 32'h0002_0000, 32'h7FFF_FFFF};
        bus.start_i = 1'b0;
        bus.x_i     = '0;
        #1;
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_done", bus.done_o, 0);
        chk("rst_err", bus.err_o, 0);
        chk("rst_x", bus.x_o, 0);
        chk("rst_k", 64'(bus.k_o), 0);
        chk("rst_corr", bus.ln2_corr_o, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);

        foreach (dir[i]) issue(dir[i]);

        // Second start while scaling must be ignored.
        @(posedge clk);
        #1;
        bus.start_i = 1'b1;
        bus.x_i     = 32'h0008_0000;
        sb.push_back(model(32'h0008_0000));
        @(posedge clk);
        #1;
        bus.x_i = 32'h0000_0400;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (10) @(posedge clk);

        // Reset pulse while scaling: outputs clear, no done afterwards.
        @(posedge clk);
        #1;
        bus.start_i = 1'b1;
        bus.x_i     = 32'h0000_0001;
        ab = model(32'h0000_0001);
        ab.abort = 1;
        sb.push_back(ab);
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", bus.busy_o, 0);
        chk("midrst_done", bus.done_o, 0);
        chk("midrst_x", bus.x_o, 0);
        chk("midrst_k", 64'(bus.k_o), 0);
        chk("midrst_corr", bus.ln2_corr_o, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        saw_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done_o || bus.busy_o) saw_done = 1;
        end
        chk("no_activity_after_rst", saw_done, 0);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 9))
                0:       xv = 32'h0;
                1:       xv = 32'h8000_0000 | $urandom;
                default: xv = $urandom >> $urandom_range(1, 31);
            endcase
            issue(xv);
        end

        repeat (5) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
